waveform_sequencer: RTL and testbench

Schedules radar pulse transmission for the waveform playback path. Each pulse it loads a waveform-parameter word into `waveform_stream`, then fires the chirp DDS (`chirp_init`) at a programmable pulse-repetition interval (PRI). It counts pulses per burst and aborts on handshake timeouts. It sits between the host configuration registers and the `waveform_stream` / `CHIRP_DDS` pair, on the same clock as both.

---
 rtl/waveform_seq_pkg.sv | 21 ++
 rtl/waveform_sequencer_timer.sv | 30 +++
 rtl/waveform_sequencer.sv | 145 ++++++++++++++
 tb/tb_waveform_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_seq_pkg.sv
// Shared types and constants for the radar pulse waveform sequencer.
package waveform_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARM,
      FIRE,
      WAIT_DONE,
      HOLDOFF
   } state_e;

   localparam int unsigned PRI_MIN           = 5;
   localparam int unsigned PRI_LAUNCH_OFFSET = 3;

   // States that wait on an external handshake and are guarded by the timeout.
   function automatic logic is_wait_state(input state_e s);
      return (s == LOAD) || (s == ARM) || (s == WAIT_DONE);
   endfunction

endpackage

// File: rtl/waveform_sequencer_timer.sv
// Clearable saturating up-counter; hit_o is high while the count is at or past cmp_i.
module seq_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] cmp_i,
   output logic         hit_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign hit_o = (cnt_q >= cmp_i);

endmodule

// File: rtl/waveform_sequencer.sv
// Pulse scheduler: loads the waveform word, fires the chirp DDS every PRI cycles,
// counts pulses per burst and aborts a stalled handshake after TIMEOUT cycles.
module waveform_sequencer
   import waveform_seq_pkg::*;
#(
   parameter int PRI_WIDTH = 32,
   parameter int TIMEOUT   = 4096
) (
   input  logic                 clk_in1,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [PRI_WIDTH-1:0] cfg_pri,
   input  logic [15:0]          cfg_num_pulses,
   input  logic [127:0]         cfg_wf_params,
   output logic [127:0]         waveform_parameters,
   output logic                 init_wf_write,
   input  logic                 wf_write_ready,
   input  logic                 chirp_ready,
   output logic                 chirp_init,
   input  logic                 chirp_done,
   output logic                 busy,
   output logic                 burst_done,
   output logic [15:0]          pulse_count,
   output logic                 timeout_err
);

   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e               state_q, state_d;
   logic [PRI_WIDTH-1:0] pri_q, pri_d;
   logic [15:0]          num_q, num_d;
   logic [127:0]         wf_q, wf_d;
   logic [15:0]          pcnt_q, pcnt_d;
   logic                 loaded_q, loaded_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 rdy_q, rdy_d;
   logic                 pri_hit, wait_hit;

   // pri_cnt reads 0 during FIRE, so launching at PRI-3 lands the next FIRE exactly PRI later.
   seq_timer #(.W(PRI_WIDTH)) u_pri_timer (
      .clk_i (clk_in1),
      .rst_ni(aresetn),
      .clr_i (state_d == FIRE),
      .inc_i (1'b1),
      .cmp_i (pri_q - PRI_WIDTH'(PRI_LAUNCH_OFFSET)),
      .hit_o (pri_hit)
   );

   seq_timer #(.W(WW)) u_wait_timer (
      .clk_i (clk_in1),
      .rst_ni(aresetn),
      .clr_i (is_wait_state(state_d) && (state_d != state_q)),
      .inc_i (is_wait_state(state_q)),
      .cmp_i (WW'(TIMEOUT - 1)),
      .hit_o (wait_hit)
   );

   always_comb begin
      state_d  = state_q;
      pri_d    = pri_q;
      num_d    = num_q;
      wf_d     = wf_q;
      pcnt_d   = pcnt_q;
      loaded_d = loaded_q;
      err_d    = err_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               pri_d    = (cfg_pri < PRI_WIDTH'(PRI_MIN)) ? PRI_WIDTH'(PRI_MIN) : cfg_pri;
               num_d    = cfg_num_pulses;
               wf_d     = cfg_wf_params;
               loaded_d = 1'b1;
               err_d    = 1'b0;
               pcnt_d   = '0;
            end else if (enable && loaded_q) begin
               state_d = LOAD;
            end
         end
         LOAD:      if (wf_write_ready) state_d = ARM;
         ARM:       if (chirp_ready)    state_d = FIRE;
         FIRE: begin
            if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: if (chirp_done)     state_d = HOLDOFF;
         HOLDOFF: begin
            if (pri_hit) begin
               if (((num_q != '0) && (pcnt_q == num_q)) || !enable) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default:   state_d = IDLE;
      endcase
      // A stalled handshake abandons the burst and forces a fresh configuration.
      if (is_wait_state(state_q) && (state_d == state_q) && wait_hit) begin
         state_d  = IDLE;
         err_d    = 1'b1;
         loaded_d = 1'b0;
      end
   end

   assign rdy_d = (state_d == IDLE);

   always_ff @(posedge clk_in1 or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         pri_q    <= '0;
         num_q    <= '0;
         wf_q     <= '0;
         pcnt_q   <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pri_q    <= pri_d;
         num_q    <= num_d;
         wf_q     <= wf_d;
         pcnt_q   <= pcnt_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         done_q   <= done_d;
         rdy_q    <= rdy_d;
      end
   end

   assign cfg_ready           = rdy_q;
   assign busy                = (state_q != IDLE);
   assign init_wf_write       = (state_q == LOAD);
   assign chirp_init          = (state_q == FIRE);
   assign burst_done          = done_q;
   assign pulse_count         = pcnt_q;
   assign timeout_err         = err_q;
   assign waveform_parameters = wf_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Scoreboarded bench: stimulus queues expected chirp/burst events, a monitor checks them.
module tb_waveform_sequencer;

   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          enable = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [PW-1:0] cfg_pri = '0;
   logic [15:0]   cfg_num = '0;
   logic [127:0]  cfg_wf = '0;
   logic          wf_tie = 1'b1;
   logic          wf_mdl = 1'b0;
   logic          chirp_rdy = 1'b1;
   logic          chirp_done = 1'b0;
   logic          wf_write_ready;

   logic [127:0]  wp, t_wp;
   logic          crdy, init, cinit, busy, bdone, terr;
   logic          t_crdy, t_init, t_cinit, t_busy, t_bdone, t_err;
   logic [15:0]   pcnt, t_pcnt;

   assign wf_write_ready = wf_tie | wf_mdl;

   waveform_sequencer #(.PRI_WIDTH(PW), .TIMEOUT(4096)) dut (
      .clk_in1(clk), .aresetn(aresetn), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(crdy), .cfg_pri(cfg_pri),
      .cfg_num_pulses(cfg_num), .cfg_wf_params(cfg_wf),
      .waveform_parameters(wp), .init_wf_write(init),
      .wf_write_ready(wf_write_ready), .chirp_ready(chirp_rdy),
      .chirp_init(cinit), .chirp_done(chirp_done), .busy(busy),
      .burst_done(bdone), .pulse_count(pcnt), .timeout_err(terr)
   );

   waveform_sequencer #(.PRI_WIDTH(PW), .TIMEOUT(16)) dut_to (
      .clk_in1(clk), .aresetn(aresetn), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(t_crdy), .cfg_pri(cfg_pri),
      .cfg_num_pulses(cfg_num), .cfg_wf_params(cfg_wf),
      .waveform_parameters(t_wp), .init_wf_write(t_init),
      .wf_write_ready(wf_write_ready), .chirp_ready(chirp_rdy),
      .chirp_init(t_cinit), .chirp_done(chirp_done), .busy(t_busy),
      .burst_done(t_bdone), .pulse_count(t_pcnt), .timeout_err(t_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // mode: 0 = no timing check, 1 = cycles since previous FIRE, 2 = absolute cycle
   typedef struct {
      bit is_burst;
      int mode;
      int t;
      int pcnt;
   } exp_t;
   exp_t exp_q[$];

   int n_chk = 0;
   int n_fail = 0;
   int last_fire = 0;
   int dds_delay = 1;
   int done_at = -1;
   int wdelay = 0;
   int wcnt = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input bit b, input int m, input int t, input int p);
      exp_t e;
      e.is_burst = b;
      e.mode     = m;
      e.t        = t;
      e.pcnt     = p;
      exp_q.push_back(e);
   endtask

   // Monitor: every chirp_init / burst_done strobe consumes one expected event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (aresetn && (cinit || bdone)) begin
            if (exp_q.size() == 0) begin
               if (cinit) chk("unexpected_fire", 1, 0);
               else       chk("unexpected_burst", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", bdone, e.is_burst);
               if (e.mode == 1) begin
                  if (bdone) chk("burst_gap", cyc - last_fire, e.t);
                  else       chk("fire_gap", cyc - last_fire, e.t);
               end else if (e.mode == 2) begin
                  chk("fire_cycle", cyc, e.t);
               end
               if (bdone) chk("burst_pulse_count", pcnt, e.pcnt);
            end
            if (cinit) last_fire = cyc;
         end
      end
   end

   // DDS model: chirp_done is high for one cycle, dds_delay cycles after the FIRE cycle.
   initial forever begin
      @(negedge clk);
      if (!aresetn)   done_at = -1;
      else if (cinit) done_at = cyc + dds_delay;
      chirp_done = (cyc == done_at);
   end

   // Waveform stream model: acknowledge after init_wf_write has been high wdelay cycles.
   initial forever begin
      @(negedge clk);
      if (init) begin
         wf_mdl = (wcnt >= wdelay);
         wcnt++;
      end else begin
         wcnt = 0;
         wf_mdl = 1'b0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      aresetn = 1'b0;
      enable  = 1'b0;
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic configure(input int pri, input int num, input logic [127:0] wf);
      @(negedge clk);
      cfg_pri   = PW'(pri);
      cfg_num   = 16'(num);
      cfg_wf    = wf;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_burst(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bdone) begin
            seen = 1;
            enable = 1'b0;
         end
      end
      chk("burst_seen", seen, 1);
   endtask

   localparam logic [127:0] WF_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   initial begin
      int g, hold, nf, L;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_init", init, 0);
      chk("rst_chirp_init", cinit, 0);
      chk("rst_burst_done", bdone, 0);
      chk("rst_pulse_count", pcnt, 0);
      chk("rst_timeout_err", terr, 0);
      chk("rst_cfg_ready", crdy, 0);
      chk("rst_wf_params", wp, 0);
      aresetn = 1'b1;
      @(negedge clk);
      chk("idle_cfg_ready", crdy, 1);

      // Burst timing: 4 pulses, PRI 1024, done 200 cycles after each FIRE
      dds_delay = 200;
      configure(1024, 4, WF_A);
      chk("wf_params", wp, WF_A);
      push(0, 2, cyc + 3, 0);
      push(0, 1, 1024, 0);
      push(0, 1, 1024, 0);
      push(0, 1, 1024, 0);
      push(1, 1, 1022, 4);
      enable = 1'b1;
      wait_burst(5000);
      @(negedge clk);
      chk("burst_q_empty", exp_q.size(), 0);
      chk("burst_pulse_count_end", pcnt, 4);
      chk("burst_idle", busy, 0);

      // PRI=2 clamps to 5
      dds_delay = 1;
      configure(2, 3, 128'h5);
      push(0, 0, 0, 0);
      push(0, 1, 5, 0);
      push(0, 1, 5, 0);
      push(1, 1, 3, 3);
      enable = 1'b1;
      wait_burst(200);
      @(negedge clk);
      chk("clamp_q_empty", exp_q.size(), 0);

      // Overrun: done 299 cycles after FIRE -> next FIRE 303 later
      dds_delay = 299;
      configure(100, 2, 128'h6);
      push(0, 0, 0, 0);
      push(0, 1, 303, 0);
      push(1, 1, 301, 2);
      enable = 1'b1;
      wait_burst(2000);
      @(negedge clk);
      chk("overrun_q_empty", exp_q.size(), 0);

      // Load handshake delayed 10 cycles
      wf_tie = 1'b0;
      wdelay = 10;
      dds_delay = 5;
      configure(20, 1, 128'h7);
      push(0, 0, 0, 0);
      push(1, 1, 18, 1);
      enable = 1'b1;
      g = 0;
      while (!init && g < 20) begin @(negedge clk); g++; end
      hold = 0;
      while (init && hold < 50) begin hold++; @(negedge clk); end
      chk("load_hold_cycles", hold, 11);
      chk("arm_no_fire", cinit, 0);
      @(negedge clk);
      chk("fire_after_ack", cinit, 1);
      wait_burst(100);
      @(negedge clk);
      chk("hs_q_empty", exp_q.size(), 0);
      wf_tie = 1'b1;

      // Continuous mode, enable dropped in WAIT_DONE of pulse 2
      dds_delay = 10;
      configure(50, 0, 128'h8);
      push(0, 0, 0, 0);
      push(0, 1, 50, 0);
      push(1, 1, 48, 2);
      enable = 1'b1;
      nf = 0;
      g = 0;
      while (nf < 2 && g < 300) begin
         @(negedge clk);
         g++;
         if (cinit) nf++;
      end
      @(negedge clk);
      enable = 1'b0;
      wait_burst(200);
      repeat (200) @(negedge clk);
      chk("cont_q_empty", exp_q.size(), 0);
      chk("cont_pulse_count", pcnt, 2);
      chk("cont_idle", busy, 0);

      // Timeout (TIMEOUT=16 instance), chirp_ready stuck low
      do_reset();
      chirp_rdy = 1'b0;
      configure(20, 1, 128'h9);
      enable = 1'b1;
      g = 0;
      while (!t_init && g < 20) begin @(negedge clk); g++; end
      L = cyc;
      while (cyc < L + 16) @(negedge clk);
      chk("to_err_before", t_err, 0);
      chk("to_busy_before", t_busy, 1);
      @(negedge clk);
      chk("to_err_set", t_err, 1);
      chk("to_busy_after", t_busy, 0);
      chk("to_no_burst_done", t_bdone, 0);
      repeat (5) @(negedge clk);
      chk("to_no_restart", t_busy, 0);
      enable = 1'b0;
      configure(20, 1, 128'h9);
      chk("to_err_cleared", t_err, 0);

      // Reset asserted mid-LOAD of pulse 2
      do_reset();
      chirp_rdy = 1'b1;
      wf_tie = 1'b0;
      wdelay = 0;
      dds_delay = 5;
      configure(20, 3, 128'hA);
      push(0, 0, 0, 0);
      enable = 1'b1;
      g = 0;
      while (!cinit && g < 20) begin @(negedge clk); g++; end
      wdelay = 10000;
      @(negedge clk);
      g = 0;
      while (!init && g < 40) begin @(negedge clk); g++; end
      chk("pre_rst_pulse_count", pcnt, 1);
      chk("pre_rst_load", init, 1);
      repeat (2) @(negedge clk);
      #2 aresetn = 1'b0;
      #1;
      chk("async_rst_init", init, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_pulse_count", pcnt, 0);
      @(negedge clk);
      enable = 1'b0;
      aresetn = 1'b1;
      wf_tie = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_q_empty", exp_q.size(), 0);
      chk("rst_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
